// File: rtl/fetch_q_pkg.sv
// Shared types for the fetch instruction queue: instruction word, queue entry
// (instruction plus last-of-program flag) and per-cycle group limits.
package fetch_q_pkg;

    localparam int XLEN    = 32;
    localparam int DEQ_MAX = 2;
    localparam int ENQ_MAX = 2;

    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        logic   last;
    } entry_t;

endpackage

// File: rtl/fetch_q_storage.sv
// Entry storage for the fetch instruction queue: DEPTH x entry_t registers,
// two write ports at waddr/waddr+1 and two async read ports at raddr/raddr+1.
// Addresses wrap naturally because they are exactly log2(DEPTH) bits wide.
module fetch_q_storage
    import fetch_q_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [PW-1:0] waddr_i,
    input  entry_t        wdata0_i,
    input  entry_t        wdata1_i,
    input  logic [PW-1:0] raddr_i,
    output entry_t        rdata0_o,
    output entry_t        rdata1_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] waddr1;
    logic [PW-1:0] raddr1;

    assign waddr1 = waddr_i + 1'b1;
    assign raddr1 = raddr_i + 1'b1;

    // Data-only array: validity lives in the top's count, so no reset needed here.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1]  <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr_i];
    assign rdata1_o = mem_q[raddr1];

endmodule

// File: rtl/fetch_instr_queue.sv
// Dual-issue fetch-to-decode instruction queue. Accepts up to two instructions
// per cycle from Fetch and presents the two oldest to decode in program order.
// Tracks the end-of-program marker and reports when the program has drained.
// Optional build macro FETCH_Q_STATS_EN adds stat_hwm / stat_stall outputs.
module fetch_instr_queue
    import fetch_q_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = fetch_q_pkg::XLEN  // must match the package instruction width
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    enq_valid,
    input  logic                    enq_two,
    input  logic [XLEN-1:0]         enq_instr1,
    input  logic [XLEN-1:0]         enq_instr2,
    input  logic                    enq_finish,
    output logic                    enq_ready,
    output logic [1:0]              deq_valid,
    output logic [XLEN-1:0]         deq_instr0,
    output logic [XLEN-1:0]         deq_instr1,
    output logic [1:0]              deq_last,
    input  logic [1:0]              deq_take,
`ifdef FETCH_Q_STATS_EN
    output logic [$clog2(DEPTH):0]  stat_hwm,
    output logic [31:0]             stat_stall,
`endif
    output logic                    drained
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          fin_q, fin_d;
    logic          drained_q, drained_d;

    logic          enq_fire;
    logic [CW-1:0] n_enq, n_deq;
    logic [1:0]    take_c;
    entry_t        wdata0, wdata1, rdata0, rdata1;

    // Acceptance and next-state: ready looks only at registered count, flush wins.
    always_comb begin
        enq_ready = (count_q <= CW'(DEPTH - 2)) && !fin_q;
        enq_fire  = enq_valid && enq_ready;
        n_enq     = enq_fire ? (enq_two ? CW'(2) : CW'(1)) : '0;
        take_c    = (deq_take == 2'd3) ? 2'd2 : deq_take;
        n_deq     = (CW'(take_c) > count_q) ? count_q : CW'(take_c);

        head_d    = head_q + PW'(n_deq);
        tail_d    = tail_q + PW'(n_enq);
        count_d   = count_q + n_enq - n_deq;
        fin_d     = fin_q | (enq_fire & enq_finish);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fin_d   = 1'b0;
        end
        drained_d = fin_d && (count_d == '0);
    end

    // Queue control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            fin_q     <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            fin_q     <= fin_d;
            drained_q <= drained_d;
        end
    end

    // The last flag belongs to the youngest instruction of a finishing group.
    always_comb begin
        wdata0.instr = enq_instr1;
        wdata0.last  = enq_finish & ~enq_two;
        wdata1.instr = enq_instr2;
        wdata1.last  = enq_finish;
    end

    fetch_q_storage #(.DEPTH(DEPTH), .PW(PW)) u_storage (
        .clk      (clk),
        .we0_i    (enq_fire & ~flush),
        .we1_i    (enq_fire & enq_two & ~flush),
        .waddr_i  (tail_q),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr_i  (head_q),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // Read slots are masked by occupancy so empty slots show zero data and flags.
    always_comb begin
        deq_valid  = {count_q >= CW'(2), count_q != '0};
        deq_instr0 = deq_valid[0] ? rdata0.instr : '0;
        deq_instr1 = deq_valid[1] ? rdata1.instr : '0;
        deq_last   = {deq_valid[1] & rdata1.last, deq_valid[0] & rdata0.last};
        drained    = drained_q;
    end

`ifdef FETCH_Q_STATS_EN
    logic [CW-1:0] hwm_q;
    logic [31:0]   stall_q;

    // High-water mark since reset/flush and saturating count of refused offers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else begin
            if (flush)                 hwm_q <= '0;
            else if (count_d > hwm_q)  hwm_q <= count_d;
            if (enq_valid && !enq_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_hwm   = hwm_q;
    assign stat_stall = stall_q;
`endif

`ifndef SYNTHESIS
    // Decode must never take more entries than are presented.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) assert (CW'(deq_take) <= count_q);
    end
`endif

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: the driver pushes accepted
// instructions into an expected queue; a negedge monitor checks status
// outputs against the model and pops/compares every entry decode takes.
module tb_fetch_instr_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    typedef struct {
        logic [XLEN-1:0] instr;
        logic            last;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_two = 1'b0;
    logic [XLEN-1:0]  enq_instr1 = '0;
    logic [XLEN-1:0]  enq_instr2 = '0;
    logic             enq_finish = 1'b0;
    logic             enq_ready;
    logic [1:0]       deq_valid;
    logic [XLEN-1:0]  deq_instr0, deq_instr1;
    logic [1:0]       deq_last;
    logic [1:0]       deq_take = 2'd0;
    logic             drained;
`ifdef FETCH_Q_STATS_EN
    logic [$clog2(DEPTH):0] stat_hwm;
    logic [31:0]            stat_stall;
`endif

    ent_t        exp_q[$];
    bit          fin;
    bit          exp_ready = 1'b1;
    int unsigned exp_stall;
    int          exp_hwm;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_two    (enq_two),
        .enq_instr1 (enq_instr1),
        .enq_instr2 (enq_instr2),
        .enq_finish (enq_finish),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .deq_instr0 (deq_instr0),
        .deq_instr1 (deq_instr1),
        .deq_last   (deq_last),
        .deq_take   (deq_take),
`ifdef FETCH_Q_STATS_EN
        .stat_hwm   (stat_hwm),
        .stat_stall (stat_stall),
`endif
        .drained    (drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: status vs model, then pop and compare every entry taken this cycle.
    always @(negedge clk) begin : monitor
        int   n;
        ent_t e;
        if (rst_n) begin
            n = exp_q.size();
            exp_ready = (n <= DEPTH - 2) && !fin;
            chk("enq_ready", 32'(enq_ready), 32'(exp_ready));
            chk("deq_valid", 32'(deq_valid), 32'({n >= 2, n >= 1}));
            chk("drained",   32'(drained),   32'(fin && n == 0));
            chk("deq_last",  32'(deq_last),
                32'({(n >= 2) && exp_q[1].last, (n >= 1) && exp_q[0].last}));
            for (int k = 0; k < 2; k++) begin
                if (k < int'(deq_take) && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(k == 0 ? "deq_instr0" : "deq_instr1",
                        (k == 0) ? deq_instr0 : deq_instr1, e.instr);
                end
            end
        end
    end

    // One cycle of stimulus; model advances at the clock edge.
    task automatic step(input bit v, input bit two, input bit finb, input int take, input bit fl);
        ent_t e;
        enq_valid  = v;
        enq_two    = two;
        enq_finish = finb;
        enq_instr1 = $urandom;
        enq_instr2 = $urandom;
        flush      = fl;
        deq_take   = 2'((take > exp_q.size()) ? exp_q.size() : take);
        @(posedge clk);
        if (v && !exp_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (fl) begin
            exp_q.delete();
            fin = 1'b0;
        end else if (v && exp_ready) begin
            e.instr = enq_instr1;
            e.last  = finb && !two;
            exp_q.push_back(e);
            if (two) begin
                e.instr = enq_instr2;
                e.last  = finb;
                exp_q.push_back(e);
            end
            if (finb) fin = 1'b1;
        end
        if (fl) exp_hwm = 0;
        else if (exp_q.size() > exp_hwm) exp_hwm = exp_q.size();
        #1;
`ifdef FETCH_Q_STATS_EN
        chk("stat_stall", stat_stall, exp_stall);
        chk("stat_hwm",   32'(stat_hwm), 32'(exp_hwm));
`endif
    endtask

    task automatic do_reset();
        enq_valid = 1'b0;
        deq_take  = 2'd0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_drained",   32'(drained),   32'd0);
        chk("rst_deq_instr0", deq_instr0,    32'd0);
        chk("rst_deq_last",  32'(deq_last),  32'd0);
        exp_q.delete();
        fin       = 1'b0;
        exp_ready = 1'b1;
        exp_stall = 0;
        exp_hwm   = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();

        // Reset mid-run with five entries held.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();

        // Fill to DEPTH, then a refused fifth pair.
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Simultaneous enq/deq: 8 -> 6, pair+take2 keeps 6, 7 refuses a pair.
        step(0, 0, 0, 2, 0);
        step(1, 1, 0, 2, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 2, 0);
        step(0, 0, 0, 0, 0);

        // Order across pointer wrap with mixed group sizes.
        repeat (12) step(1, 1'($urandom_range(0, 1)), 0, 2, 0);
        repeat (5) step(0, 0, 0, 2, 0);

        // Finish marker: last flag on the younger entry, then drain.
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Flush with five entries and finish seen, racing an enq and a take.
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 2, 1);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with occasional finish and flush.
        repeat (500) begin
            step(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 25) == 0,
                 int'($urandom_range(0, 2)), ($urandom % 40) == 0);
        end
        repeat (6) step(0, 0, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
